data_memory_unit: RTL
=====================

Name: data_memory_unit

Overview:
Data memory of the Risky core. It sits directly downstream of the core's data-memory port (read, write, address, data_out) and returns data_in to the core's write-back stage. The block holds a word-addressed RAM and a small memory-mapped I/O window at the top of the address space:
- an output stream FIFO with a valid/ready handshake toward a consumer, e.g. a UART or testbench sink;
- a status register.

Parameters:
ADDR_W, `ADDRESS_SIZE, address width; matches the core address port.
DATA_W, `DATA_SIZE, word width; matches the core data ports.
RAM_DEPTH, 256, number of RAM words, mapped at addresses 0..RAM_DEPTH-1. Must be ≤ 2^ADDR_W - 3.
FIFO_DEPTH, 4, stream FIFO entries. Must be a power of two, 2..16.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous reset, active-low (0 = reset), sampled on rising edge of clock
read  input  1  core memory read strobe (active 1)
write  input  1  core memory write strobe (active 1)
address  input  ADDR_W  word address from core
data_in  input  DATA_W  write data from core (core data_out)
data_out  output  DATA_W  read data to core (core data_in)
stream_data  output  DATA_W  FIFO head word
stream_valid  output  1  FIFO non-empty
stream_ready  input  1  consumer accepts head this cycle

Behaviour:
- Address map (A = 2^ADDR_W - 1):
  - 0..RAM_DEPTH-1: RAM.
  - A: OUT_DATA (write-only).
  - A-1: OUT_STATUS (read/write).
  - A-2: TIMER.
  - All other addresses: reads return 0, writes are ignored.
- Reads are combinational, zero latency: data_out is valid in the same cycle as read/address, because the core consumes it in that cycle. data_out = 0 whenever read = 0.
- Writes take effect on the rising edge. If read and write are asserted together, data_out returns the pre-write value.
- RAM contents are not reset. Simulation initial value is X.
- Writing OUT_DATA pushes data_in into the FIFO.
  - If the FIFO is full and stream_ready = 0: the word is dropped and the sticky overflow flag is set.
  - If the FIFO is full and stream_ready = 1 in the same cycle: pop and push both happen, the count is unchanged, and no overflow occurs.
- Pop occurs when stream_valid && stream_ready.
- stream_valid = (count != 0). stream_data = the head entry, taken from storage flops.
- While stream_valid = 1 and stream_ready = 0, stream_data and stream_valid hold stable.
- Simultaneous push and pop on an empty FIFO: no pop, because valid = 0. The push lands.
- OUT_STATUS read format:
  - bit0 = empty;
  - bit1 = full;
  - bit2 = overflow;
  - bits[8:4] = count (0..FIFO_DEPTH);
  - all other bits 0.
- Any write to OUT_STATUS clears overflow. The written data is ignored.
- Reads of OUT_DATA return 0.
- Reset (reset = 0 at an edge):
  - FIFO count, read pointer, write pointer and overflow go to 0;
  - the timer goes to 0;
  - stream_valid = 0 from the next cycle;
  - any push or pop in that cycle is discarded.
- Pointers wrap modulo FIFO_DEPTH. Count is tracked separately so that full and empty are unambiguous.

Optional Feature:
Macro: DMEM_TIMER_EN.
- Defined:
  - TIMER is a DATA_W free-running counter, incremented every non-reset cycle, wrapping from all-ones to 0.
  - Reads return the current counter value.
  - A write loads data_in; the counter resumes incrementing from data_in on the following cycle.
- Undefined:
  - TIMER reads 0 and writes are ignored.
  - No counter flops are instantiated.

Decomposition:
- Shared include dmem_map.vh holds:
  - the MMIO offset constants (OUT_DATA_OFF = 0, OUT_STATUS_OFF = 1, TIMER_OFF = 2, counted down from A);
  - the status bit positions (STAT_EMPTY, STAT_FULL, STAT_OVF, STAT_COUNT_LSB).
- The include uses `ADDRESS_SIZE/`DATA_SIZE from architecture.vh.
- One sub-module, stream_fifo: a parameterised synchronous FIFO with push/full/pop/valid/count. It holds no overflow logic; overflow stays in the parent.

Test Plan:
- RAM write/read: write 0xDEADBEEF to address 5, then read address 5 → data_out = 0xDEADBEEF in the same cycle as read. A read with read = 0 → data_out = 0.
- Stream handshake: stream_ready = 0, write 0x11, 0x22, 0x33 to OUT_DATA.
  - Status read → count = 3, empty = 0.
  - Raise stream_ready → 0x11, 0x22, 0x33 are observed in order, one per cycle.
  - Then stream_valid = 0.
- Overflow: stream_ready = 0, FIFO_DEPTH = 4, write 5 words.
  - Status → full = 1, overflow = 1, count = 4.
  - The 5th word is never emitted.
  - Write OUT_STATUS → overflow = 0.
- Full with simultaneous pop: FIFO full, write 0x55 with stream_ready = 1 → head popped, 0x55 accepted, count stays 4, overflow stays 0.
- Reset mid-operation: 2 words queued, assert reset = 0 for one edge → stream_valid = 0 and status count = 0. Data previously written to RAM address 5 still reads back unchanged.
- Timer (DMEM_TIMER_EN defined): write 100 to TIMER, read it 3 cycles later → 103. A write of 0xFFFFFFFF followed by a read 1 cycle later → 0 (wrap). With DMEM_TIMER_EN undefined, TIMER reads 0.

Source files
------------

// File: rtl/data_memory_unit_pkg.sv
// Shared definitions for the Risky data memory: default architecture widths,
// MMIO offsets (counted down from the top address), status bit positions and
// the address-region type used by the decoder.
// The address/data widths come from the architecture macros
// ADDRESS_SIZE and DATA_SIZE. If these are not already defined, they
// default to 32 bits.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package data_memory_unit_pkg;

   // MMIO offsets below the all-ones address
   localparam int OUT_DATA_OFF   = 0;
   localparam int OUT_STATUS_OFF = 1;
   localparam int TIMER_OFF      = 2;

   // OUT_STATUS bit positions
   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_COUNT_LSB = 4;
   localparam int STAT_COUNT_W   = 5;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_OUT_DATA,
      SEL_STATUS,
      SEL_TIMER
   } region_e;

endpackage

// File: rtl/stream_fifo.sv
// Parameterised synchronous FIFO feeding the output stream.
// The head word comes straight from the storage flops. A push into a full
// FIFO is still accepted when a pop happens in the same cycle. Dropped pushes
// are reported by the parent; this block only refuses them.
module stream_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   output logic              full,
   input  logic              pop,
   output logic              valid,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count
);

   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign valid     = (count_reg != '0);
   assign full      = (count_reg == CNT_W'(DEPTH));
   assign count     = count_reg;
   assign head_data = mem_reg[rd_ptr_reg];
   assign do_pop    = pop && valid;
   assign do_push   = push && (!full || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two; the separate
   // count keeps full and empty distinguishable.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage is not reset; a push during reset is discarded
   always_ff @(posedge clock) begin
      if (reset && do_push) mem_reg[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/data_memory_unit.sv
// Data memory of the Risky core: word-addressed RAM at the bottom of the
// address space, plus an MMIO window at the top. The window contains the
// OUT_DATA stream FIFO, the OUT_STATUS register and the optional TIMER.
// Reads are combinational so the core sees data in the same cycle.
// Optional feature macro: DMEM_TIMER_EN (free-running TIMER register).
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module data_memory_unit
   import data_memory_unit_pkg::*;
#(
   parameter int ADDR_W     = `ADDRESS_SIZE,
   parameter int DATA_W     = `DATA_SIZE,
   parameter int RAM_DEPTH  = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic [DATA_W-1:0] stream_data,
   output logic              stream_valid,
   input  logic              stream_ready
);

   localparam int RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_W-1:0] ADDR_TOP      = '1;
   localparam logic [ADDR_W-1:0] RAM_LIMIT     = ADDR_W'(RAM_DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_OUT_DATA = ADDR_TOP - ADDR_W'(OUT_DATA_OFF);
   localparam logic [ADDR_W-1:0] ADDR_STATUS   = ADDR_TOP - ADDR_W'(OUT_STATUS_OFF);
   localparam logic [ADDR_W-1:0] ADDR_TIMER    = ADDR_TOP - ADDR_W'(TIMER_OFF);

   region_e           region;
   logic [DATA_W-1:0] ram_mem [RAM_DEPTH];
   logic [DATA_W-1:0] status_word;
   logic [DATA_W-1:0] timer_value;
   logic              ovf_reg;
   logic              wr_out;
   logic              wr_status;
   logic              push_drop;
   logic              fifo_full;
   logic [CNT_W-1:0]  fifo_count;

   // Decode the word address into one region
   always_comb begin
      region = SEL_NONE;
      if (address < RAM_LIMIT)           region = SEL_RAM;
      else if (address == ADDR_OUT_DATA) region = SEL_OUT_DATA;
      else if (address == ADDR_STATUS)   region = SEL_STATUS;
      else if (address == ADDR_TIMER)    region = SEL_TIMER;
   end

   assign wr_out    = write && (region == SEL_OUT_DATA);
   assign wr_status = write && (region == SEL_STATUS);
   // A push into a full FIFO is only lost when nothing leaves that cycle
   assign push_drop = wr_out && fifo_full && !stream_ready;

   // RAM write port; contents are deliberately left unreset
   always_ff @(posedge clock) begin
      if (write && (region == SEL_RAM)) ram_mem[address[RAM_AW-1:0]] <= data_in;
   end

   // Sticky overflow: set by a dropped push, cleared by any status write
   always_ff @(posedge clock) begin
      if (!reset)         ovf_reg <= 1'b0;
      else if (wr_status) ovf_reg <= 1'b0;
      else if (push_drop) ovf_reg <= 1'b1;
   end

   stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_stream_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (wr_out),
      .push_data (data_in),
      .full      (fifo_full),
      .pop       (stream_ready),
      .valid     (stream_valid),
      .head_data (stream_data),
      .count     (fifo_count)
   );

`ifdef DMEM_TIMER_EN
   logic [DATA_W-1:0] timer_reg;
   logic              wr_timer;

   assign wr_timer    = write && (region == SEL_TIMER);
   assign timer_value = timer_reg;

   // Free-running counter; a write loads it and counting resumes from there
   always_ff @(posedge clock) begin
      if (!reset)        timer_reg <= '0;
      else if (wr_timer) timer_reg <= data_in;
      else               timer_reg <= timer_reg + 1'b1;
   end
`else
   assign timer_value = '0;
`endif

   // Assemble the OUT_STATUS read word
   always_comb begin
      status_word             = '0;
      status_word[STAT_EMPTY] = !stream_valid;
      status_word[STAT_FULL]  = fifo_full;
      status_word[STAT_OVF]   = ovf_reg;
      status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
   end

   // Zero-latency read mux; idle reads and OUT_DATA reads return zero
   always_comb begin
      data_out = '0;
      if (read) begin
         case (region)
            SEL_RAM:    data_out = ram_mem[address[RAM_AW-1:0]];
            SEL_STATUS: data_out = status_word;
            SEL_TIMER:  data_out = timer_value;
            default:    data_out = '0;
         endcase
      end
   end

endmodule
